// File: rtl/writeback_stage.sv
// Writeback stage: captures a memory-stage instruction, waits for load data when needed and issues one register-file write.
// Optional build macro WB_MISALIGN_CHECK_EN adds output w_misaligned and suppresses the write of misaligned loads.

package writeback_pkg;
    typedef enum logic [1:0] {
        RESULT_SRC_ALU       = 2'd0,
        RESULT_SRC_MEMORY    = 2'd1,
        RESULT_SRC_PC_PLUS_4 = 2'd2
    } result_src_t;

    typedef enum logic [2:0] {
        MEM_SIZE_BYTE   = 3'd0,
        MEM_SIZE_HALF   = 3'd1,
        MEM_SIZE_WORD   = 3'd2,
        MEM_SIZE_DOUBLE = 3'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        LOAD_UNSIGNED = 2'd0,
        LOAD_SIGNED   = 2'd1
    } load_sign_t;
endpackage

// state | meaning
// IDLE  | nothing held, ready for a new instruction
// WAIT  | load captured, waiting for dmem_rvalid
// DONE  | result on w_*, a new instruction may be captured in the same cycle
module writeback_stage
    import writeback_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m_valid,
    output logic                 m_ready,
    input  logic [XLEN-1:0]      m_alu_result,
    input  logic [RF_ADDR_W-1:0] m_rd,
    input  logic [XLEN-1:0]      m_pc_plus_4,
    input  result_src_t          m_result_src,
    input  mem_size_t            m_mem_size,
    input  load_sign_t           m_load_sign,
    input  logic                 dmem_rvalid,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 w_valid,
    output logic [XLEN-1:0]      w_result,
    output logic [RF_ADDR_W-1:0] w_rd
`ifdef WB_MISALIGN_CHECK_EN
    ,
    output logic                 w_misaligned
`endif
);

    localparam int OFF_W = $clog2(XLEN / 8);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                 r_state;
    logic                   r_valid;
    logic [XLEN-1:0]        r_result;
    logic [RF_ADDR_W-1:0]   r_rd;
    logic [OFF_W-1:0]       r_off;
    mem_size_t              r_size;
    load_sign_t             r_sign;
    logic [RF_ADDR_W-1:0]   r_load_rd;

    logic [XLEN-1:0]        w_shifted;
    logic [XLEN-1:0]        w_mask;
    logic [6:0]             w_bits;
    logic                   w_msb;
    logic [XLEN-1:0]        w_load_data;

    // Offset bits kept for the lane select; bits below the access size are dropped.
    function automatic logic [OFF_W-1:0] align_mask(input mem_size_t size);
        case (size)
            MEM_SIZE_BYTE:   return '1;
            MEM_SIZE_HALF:   return ~OFF_W'(1);
            MEM_SIZE_WORD:   return ~OFF_W'(3);
            MEM_SIZE_DOUBLE: return (XLEN == 64) ? ~OFF_W'(7) : ~OFF_W'(3);
            default:         return '0;
        endcase
    endfunction

    function automatic logic [6:0] access_bits(input mem_size_t size);
        case (size)
            MEM_SIZE_BYTE:   return 7'd8;
            MEM_SIZE_HALF:   return 7'd16;
            MEM_SIZE_WORD:   return 7'd32;
            MEM_SIZE_DOUBLE: return (XLEN == 64) ? 7'd64 : 7'd32;
            default:         return 7'(XLEN);
        endcase
    endfunction

    always_comb begin
        w_shifted   = dmem_rdata >> {r_off & align_mask(r_size), 3'b000};
        w_bits      = access_bits(r_size);
        w_mask      = (w_bits >= 7'(XLEN)) ? '1 : (XLEN'(1) << w_bits) - XLEN'(1);
        w_msb       = |(w_shifted & (w_mask ^ (w_mask >> 1)));
        w_load_data = w_shifted & w_mask;
        // Anything other than an explicit unsigned load is sign-extended.
        if (r_sign != LOAD_UNSIGNED && w_msb) begin
            w_load_data = w_load_data | ~w_mask;
        end
    end

`ifdef WB_MISALIGN_CHECK_EN
    logic r_misaligned;
    logic w_load_misaligned;
    assign w_load_misaligned = |(r_off & ~align_mask(r_size));
    assign w_misaligned      = r_misaligned;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_rd      <= '0;
            r_off     <= '0;
            r_size    <= MEM_SIZE_BYTE;
            r_sign    <= LOAD_UNSIGNED;
            r_load_rd <= '0;
`ifdef WB_MISALIGN_CHECK_EN
            r_misaligned <= 1'b0;
`endif
        end else begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_rd     <= '0;
`ifdef WB_MISALIGN_CHECK_EN
            r_misaligned <= 1'b0;
`endif
            case (r_state)
                WAIT: begin
                    if (dmem_rvalid) begin
                        r_state  <= DONE;
                        r_valid  <= 1'b1;
                        r_result <= w_load_data;
`ifdef WB_MISALIGN_CHECK_EN
                        r_misaligned <= w_load_misaligned;
                        r_rd         <= w_load_misaligned ? '0 : r_load_rd;
`else
                        r_rd <= r_load_rd;
`endif
                    end
                end
                default: begin
                    if (m_valid) begin
                        r_off     <= m_alu_result[OFF_W-1:0];
                        r_load_rd <= m_rd;
                        r_size    <= m_mem_size;
                        r_sign    <= m_load_sign;
                        if (m_result_src == RESULT_SRC_MEMORY) begin
                            r_state <= WAIT;
                        end else begin
                            r_state <= DONE;
                            r_valid <= 1'b1;
                            r_rd    <= m_rd;
                            case (m_result_src)
                                RESULT_SRC_ALU:       r_result <= m_alu_result;
                                RESULT_SRC_PC_PLUS_4: r_result <= m_pc_plus_4;
                                default:              r_result <= '0;
                            endcase
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign m_ready  = (r_state != WAIT);
    assign w_valid  = r_valid;
    assign w_result = r_result;
    assign w_rd     = r_rd;

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter RF_ADDR_W, default 5, destination register index width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port m_valid  input  1  memory stage presents an instruction.
REQ-006 SHALL have port m_ready  output  1  stage can accept an instruction this cycle.
REQ-007 SHALL have port m_alu_result  input  XLEN  ALU result / load address.
REQ-008 SHALL have port m_rd  input  RF_ADDR_W  destination register.
REQ-009 SHALL have port m_pc_plus_4  input  XLEN  link value.
REQ-010 SHALL have ports m_result_src, m_mem_size, m_load_sign  input  result_src_t/mem_size_t/load_sign_t  control for the instruction.
REQ-011 SHALL have port dmem_rvalid  input  1  load data valid from data memory.
REQ-012 SHALL have port dmem_rdata  input  XLEN  load data, naturally aligned XLEN-bit beat.
REQ-013 SHALL have ports w_valid  output  1, w_result  output  XLEN, w_rd  output  RF_ADDR_W  register-file write.

Function
REQ-014 SHALL implement states IDLE, WAIT, DONE; m_ready = 1 in IDLE and DONE, 0 in WAIT.
REQ-015 SHALL capture all m_* fields when m_valid && m_ready.
REQ-016 On capture, SHALL go to WAIT if m_result_src = RESULT_SRC_MEMORY, else to DONE.
REQ-017 In WAIT, SHALL stay until dmem_rvalid = 1, then latch dmem_rdata and go to DONE; dmem_rvalid outside WAIT SHALL be ignored.
REQ-018 In DONE, SHALL assert w_valid for exactly that cycle; next state is WAIT/DONE on a new capture, else IDLE (back-to-back non-loads give one result per cycle).
REQ-019 w_result SHALL be the ALU result, extracted load data, or pc_plus_4 per captured result_src; unknown encoding -> 0.
REQ-020 Load extraction SHALL select the lane at byte offset = address[log2(XLEN/8)-1:0] for byte, half, word (and double when XLEN = 64), then zero- or sign-extend per load_sign; unknown load_sign -> signed; unknown mem_size -> full XLEN beat.
REQ-021 With XLEN = 32 a double-size request SHALL be treated as word.
REQ-022 When w_valid = 0, w_rd SHALL be 0 and w_result SHALL be 0.
REQ-023 Latency: non-load result 1 cycle after capture; load result 1 cycle after dmem_rvalid.

Reset
REQ-024 Reset SHALL force state IDLE, w_valid = 0, w_rd = 0, w_result = 0, m_ready = 1 and clear all captured registers, immediately and independent of clk.
REQ-025 Reset during WAIT SHALL abandon the load; a dmem_rvalid arriving after release SHALL be ignored.

Configuration
REQ-026 With macro WB_MISALIGN_CHECK_EN defined, SHALL add output w_misaligned (1 bit), asserted with w_valid when a load's offset is not a multiple of its size; on that cycle w_rd SHALL be 0.
REQ-027 Without WB_MISALIGN_CHECK_EN, w_misaligned SHALL not exist and offset low bits below the access size SHALL be ignored (access aligned down).

Verification
REQ-028 XLEN=32, ALU op rd=5 result 0x1234 -> w_valid one cycle later, w_rd=5, w_result=0x0000_1234.
REQ-029 Signed byte load addr 0x3, dmem_rdata 0x80FF_FFFF after 3 wait cycles -> m_ready low 3 cycles, then w_result=0xFFFF_FF80.
REQ-030 Unsigned half load addr 0x2, data 0xBEEF_0000 -> w_result=0x0000_BEEF; XLEN=64 signed word load addr 0x4, data 0x8000_0000_0000_0000 -> 0xFFFF_FFFF_8000_0000.
REQ-031 Three back-to-back ALU ops with m_valid held -> three consecutive w_valid cycles, no bubbles.
REQ-032 Reset asserted mid-WAIT, dmem_rvalid pulsed after release -> no w_valid; with WB_MISALIGN_CHECK_EN, word load addr 0x2 -> w_misaligned=1, w_rd=0.
